// File: rtl/ysyx_25020037_hzu.sv
// Hazard/issue scheduler between decode and execute: a per-GPR pending-write
// scoreboard gates issue on RAW hazards and an in-flight limit, and serialises CSR-class ops.
module ysyx_25020037_hzu #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [4:0] issue_rs1,
    input  logic [4:0] issue_rs2,
    input  logic       issue_rs1_en,
    input  logic       issue_rs2_en,
    input  logic [4:0] issue_rd,
    input  logic       issue_rd_we,
    input  logic       issue_serial,
    input  logic       flush,
    input  logic       retire_valid,
    input  logic [4:0] retire_rd,
    input  logic       retire_rd_we,
    input  logic       retire_serial,
    output logic [2:0] inflight_cnt,
    output logic [1:0] hz_state,
    output logic       underflow_err
);

    localparam int unsigned     NREG    = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SERIAL = 2'd2
    } state_e;

    state_e           state_q;
    logic [2:0]       inflight_q, inflight_d;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    logic raw, rd_sat, ready_base, fire;
    logic inc_en, dec_en, cnt_uflow, infl_uflow;

    // Hazard checks look at registered counters only; a retire unblocks a cycle later.
    always_comb begin
        raw = (issue_rs1_en && (cnt_q[issue_rs1] != '0)) ||
              (issue_rs2_en && (cnt_q[issue_rs2] != '0));
        rd_sat = issue_rd_we && (issue_rd != 5'd0) && (cnt_q[issue_rd] == CNT_MAX);
        ready_base = !rst && !flush && !raw && !rd_sat &&
                     (inflight_q < 3'(MAX_INFLIGHT));
        issue_ready = 1'b0;
        unique case (state_q)
            RUN:     issue_ready = ready_base && !issue_serial;
            DRAIN:   issue_ready = ready_base && issue_serial && (inflight_q == 3'd0);
            default: issue_ready = 1'b0;
        endcase
    end

    assign fire = issue_valid && issue_ready;

    // Next-state for the scoreboard and the in-flight counter; x0 stays untracked.
    always_comb begin
        inc_en     = fire && issue_rd_we && (issue_rd != 5'd0);
        dec_en     = retire_valid && retire_rd_we && (retire_rd != 5'd0);
        cnt_uflow  = dec_en && (cnt_q[retire_rd] == '0);
        infl_uflow = retire_valid && (inflight_q == 3'd0);
        for (int i = 0; i < int'(NREG); i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_en && (issue_rd == 5'(i)) && !(dec_en && (retire_rd == 5'(i)))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec_en && (retire_rd == 5'(i)) &&
                         !(inc_en && (issue_rd == 5'(i))) && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        cnt_d[0] = '0;

        inflight_d = inflight_q;
        if (fire && !retire_valid) begin
            inflight_d = inflight_q + 3'd1;
        end else if (!fire && retire_valid && (inflight_q != 3'd0)) begin
            inflight_d = inflight_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            inflight_q <= 3'd0;
            err_q      <= 1'b0;
            cnt_q      <= '{default: '0};
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            if (infl_uflow || cnt_uflow) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                RUN: begin
                    if (issue_valid && issue_serial && !flush) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (fire)                         state_q <= SERIAL;
                    else if (!issue_valid || flush)   state_q <= RUN;
                end
                SERIAL: begin
                    if (retire_valid && retire_serial) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign inflight_cnt  = inflight_q;
    assign hz_state      = state_q;
    assign underflow_err = err_q;

endmodule
